// File: rtl/seven_segment_scan_driver.sv
// seven_segment_scan_driver
//   Drives a row of common-anode seven-segment digits by time multiplexing.
//   A snapshot of value/dp_in/digit_en is captured on load. One digit is
//   shown per REFRESH_DIV-cycle slot. The first BLANK_CYCLES cycles of each
//   slot keep every anode off to suppress ghosting.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   value             packed hex nibbles, nibble 0 is the rightmost digit
//   dp_in, digit_en   per-digit decimal point / enable
//   blank_lz          suppress leading zeros (digit 0 is always shown)
//   load              capture value, dp_in and digit_en into the snapshot
//   s_a..s_g, dp      segment drives, active-low
//   anode             digit enables, active-low, at most one low
//   digit_idx         current slot index

// Per-digit hex decode. seg is active-high {g,f,e,d,c,b,a}.
module seg_digit_lane (
  input  logic [3:0] nibble,
  output logic [6:0] seg,
  output logic       nz
);
  always_comb begin
    seg = 7'h00;
    unique case (nibble)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
    endcase
  end
  assign nz = |nibble;
endmodule

module seven_segment_scan_driver #(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000,
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    blank_lz,
  input  logic                    load,
  output logic                    s_a,
  output logic                    s_b,
  output logic                    s_c,
  output logic                    s_d,
  output logic                    s_e,
  output logic                    s_f,
  output logic                    s_g,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [IDX_W-1:0]        digit_idx
);
  localparam int PRE_W = $clog2(REFRESH_DIV);

  logic [PRE_W-1:0]        pre, pre_nxt;
  logic [IDX_W-1:0]        idx, idx_nxt;
  logic                    wrap;
  logic [4*NUM_DIGITS-1:0] val_q, val_d;
  logic [NUM_DIGITS-1:0]   dpin_q, dpin_d, en_q, en_d;

  // Outputs are built from next-state values so they move on the same edge
  // as digit_idx, and a load takes effect on the edge that captures it.
  assign wrap    = (pre == PRE_W'(REFRESH_DIV - 1));
  assign pre_nxt = wrap ? '0 : pre + PRE_W'(1);
  assign val_d   = load ? value    : val_q;
  assign dpin_d  = load ? dp_in    : dpin_q;
  assign en_d    = load ? digit_en : en_q;

  always_comb begin
    idx_nxt = idx;
    if (wrap)
      idx_nxt = (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
  end

  logic [NUM_DIGITS-1:0][6:0] lane_seg;
  logic [NUM_DIGITS-1:0]      lane_nz;

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_lane
    seg_digit_lane u_lane (
      .nibble (val_d[4*k +: 4]),
      .seg    (lane_seg[k]),
      .nz     (lane_nz[k])
    );
  end

  logic past_blank;
  if (BLANK_CYCLES == 0) begin : g_noblank
    assign past_blank = 1'b1;
  end else begin : g_blank
    assign past_blank = (pre_nxt >= PRE_W'(BLANK_CYCLES));
  end

  // Walk from the most significant digit down; a digit is a leading zero
  // while no nonzero nibble has been seen at or above it.
  logic [NUM_DIGITS-1:0] lz_blank;
  logic                  above_nz;
  always_comb begin
    lz_blank = '0;
    above_nz = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      above_nz = above_nz | lane_nz[k];
      if (blank_lz && k != 0 && !above_nz) lz_blank[k] = 1'b1;
    end
  end

  logic [6:0] sel_seg;
  logic       sel_dp, sel_en, sel_lz, lit;
  always_comb begin
    sel_seg = '0;
    sel_dp  = 1'b0;
    sel_en  = 1'b0;
    sel_lz  = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_nxt == IDX_W'(k)) begin
        sel_seg = lane_seg[k];
        sel_dp  = dpin_d[k];
        sel_en  = en_d[k];
        sel_lz  = lz_blank[k];
      end
    end
  end
  assign lit = past_blank & sel_en & ~sel_lz;

  logic [NUM_DIGITS-1:0] anode_q;
  logic [6:0]            seg_q;
  logic                  dp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pre     <= '0;
      idx     <= '0;
      val_q   <= '0;
      dpin_q  <= '0;
      en_q    <= '0;
      anode_q <= '1;
      seg_q   <= '1;
      dp_q    <= 1'b1;
    end else begin
      pre     <= pre_nxt;
      idx     <= idx_nxt;
      val_q   <= val_d;
      dpin_q  <= dpin_d;
      en_q    <= en_d;
      anode_q <= lit ? ~(NUM_DIGITS'(1) << idx_nxt) : '1;
      seg_q   <= lit ? ~sel_seg : '1;
      dp_q    <= lit ? ~sel_dp : 1'b1;
    end
  end

  assign {s_g, s_f, s_e, s_d, s_c, s_b, s_a} = seg_q;
  assign dp        = dp_q;
  assign anode     = anode_q;
  assign digit_idx = idx;
endmodule

// File: tb/tb_seven_segment_scan_driver.sv
module tb_seven_segment_scan_driver;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0, digit_en = '0;
  logic        blank_lz = 1'b0, load = 1'b0;
  logic        s_a, s_b, s_c, s_d, s_e, s_f, s_g, dp;
  logic [3:0]  anode;
  logic [1:0]  digit_idx;
  logic [6:0]  segs;
  int          checks = 0, failures = 0;

  assign segs = {s_g, s_f, s_e, s_d, s_c, s_b, s_a};

  seven_segment_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .digit_en(digit_en),
    .blank_lz(blank_lz), .load(load), .s_a(s_a), .s_b(s_b), .s_c(s_c),
    .s_d(s_d), .s_e(s_e), .s_f(s_f), .s_g(s_g), .dp(dp), .anode(anode),
    .digit_idx(digit_idx)
  );

  always #5 clk = ~clk;

  // Expected scan of a fully enabled display, cycles c1..c17 after restart.
  localparam logic [3:0] SCAN_AN [17] = '{4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD, 4'hF,
                                          4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7, 4'hF, 4'hE};
  localparam logic [1:0] SCAN_IDX [17] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2,
                                           2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0};

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One reset edge, then release with a load; afterwards the DUT sits in
  // slot 0, prescaler 1 (cycle c1), showing the loaded data.
  task automatic restart(input logic [15:0] v, input logic [3:0] en, input logic [3:0] d,
                         input logic lz);
    rst = 1'b1; load = 1'b0;
    step(1);
    rst = 1'b0; load = 1'b1; value = v; digit_en = en; dp_in = d; blank_lz = lz;
    step(1);
    load = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; load = 1'b1; value = 16'hFFFF; digit_en = 4'hF; dp_in = 4'hF;
    for (int i = 0; i < 3; i++) begin
      step(1);
      checks++;
      if (anode !== 4'hF || segs !== 7'h7F || dp !== 1'b1 || digit_idx !== 2'd0) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d anode=%h segs=%h dp=%b idx=%0d want F/7F/1/0",
                 i, anode, segs, dp, digit_idx);
      end
    end
    rst = 1'b0; load = 1'b0;
    step(1);
    checks++;
    if (anode !== 4'hF || digit_idx !== 2'd0) begin
      failures++;
      $display("FAIL reset_beats_load anode=%h idx=%0d want F/0", anode, digit_idx);
    end
    step(3);
    checks++;
    if (anode !== 4'hF || digit_idx !== 2'd1) begin
      failures++;
      $display("FAIL reset_first_wrap anode=%h idx=%0d want F/1", anode, digit_idx);
    end
  endtask

  task automatic test_scan;
    restart(16'h0000, 4'hF, 4'h0, 1'b0);
    for (int c = 0; c < 17; c++) begin
      if (c > 0) step(1);
      checks++;
      if (anode !== SCAN_AN[c] || digit_idx !== SCAN_IDX[c] ||
          segs !== ((SCAN_AN[c] == 4'hF) ? 7'h7F : 7'h40) || dp !== 1'b1) begin
        failures++;
        $display("FAIL scan c%0d anode=%h idx=%0d segs=%h dp=%b want %h/%0d",
                 c + 1, anode, digit_idx, segs, dp, SCAN_AN[c], SCAN_IDX[c]);
      end
    end
  endtask

  task automatic test_hex_decode;
    restart(16'hA5F0, 4'hF, 4'h0, 1'b0);
    checks++;
    if (anode !== 4'hE || segs !== 7'h40) begin
      failures++; $display("FAIL hex_d0 anode=%h segs=%h want E/40", anode, segs);
    end
    step(3); // c4 blank
    checks++;
    if (anode !== 4'hF || segs !== 7'h7F) begin
      failures++; $display("FAIL hex_blank anode=%h segs=%h want F/7F", anode, segs);
    end
    step(1); // c5
    checks++;
    if (anode !== 4'hD || segs !== 7'h0E) begin
      failures++; $display("FAIL hex_d1 anode=%h segs=%h want D/0E", anode, segs);
    end
    step(4); // c9
    checks++;
    if (anode !== 4'hB || segs !== 7'h12) begin
      failures++; $display("FAIL hex_d2 anode=%h segs=%h want B/12", anode, segs);
    end
    step(4); // c13
    checks++;
    if (anode !== 4'h7 || segs !== 7'h08) begin
      failures++; $display("FAIL hex_d3 anode=%h segs=%h want 7/08", anode, segs);
    end
  endtask

  task automatic test_lz;
    restart(16'h0070, 4'hF, 4'h0, 1'b1);
    checks++;
    if (anode !== 4'hE || segs !== 7'h40) begin
      failures++; $display("FAIL lz_d0 anode=%h segs=%h want E/40", anode, segs);
    end
    step(4); // c5
    checks++;
    if (anode !== 4'hD || segs !== 7'h78) begin
      failures++; $display("FAIL lz_d1 anode=%h segs=%h want D/78", anode, segs);
    end
    for (int c = 9; c <= 15; c++) begin
      step((c == 9) ? 4 : 1);
      checks++;
      if (anode !== 4'hF || segs !== 7'h7F) begin
        failures++; $display("FAIL lz_upper c%0d anode=%h segs=%h want F/7F", c, anode, segs);
      end
    end
    load = 1'b1; value = 16'h0000;
    step(1); // c16
    load = 1'b0;
    step(1); // c17
    checks++;
    if (anode !== 4'hE || segs !== 7'h40) begin
      failures++; $display("FAIL lz_zero_d0 anode=%h segs=%h want E/40", anode, segs);
    end
    for (int s = 1; s < 4; s++) begin
      step(4);
      checks++;
      if (anode !== 4'hF || digit_idx !== 2'(s)) begin
        failures++;
        $display("FAIL lz_zero_d%0d anode=%h idx=%0d want F/%0d", s, anode, digit_idx, s);
      end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_en_dp;
    restart(16'h0000, 4'b0101, 4'b0100, 1'b0);
    checks++;
    if (anode !== 4'hE || dp !== 1'b1) begin
      failures++; $display("FAIL en_d0 anode=%h dp=%b want E/1", anode, dp);
    end
    step(4); // c5
    checks++;
    if (anode !== 4'hF || segs !== 7'h7F) begin
      failures++; $display("FAIL en_d1_off anode=%h segs=%h want F/7F", anode, segs);
    end
    step(3); // c8 blank of slot 2
    checks++;
    if (anode !== 4'hF || dp !== 1'b1) begin
      failures++; $display("FAIL dp_blank anode=%h dp=%b want F/1", anode, dp);
    end
    step(1); // c9
    checks++;
    if (anode !== 4'hB || dp !== 1'b0) begin
      failures++; $display("FAIL dp_d2 anode=%h dp=%b want B/0", anode, dp);
    end
    step(4); // c13
    checks++;
    if (anode !== 4'hF || dp !== 1'b1) begin
      failures++; $display("FAIL en_d3_off anode=%h dp=%b want F/1", anode, dp);
    end
  endtask

  task automatic test_load_timing;
    restart(16'h1111, 4'hF, 4'h0, 1'b0);
    step(8); // c9
    value = 16'h8888;
    step(1); // c10, no load
    checks++;
    if (anode !== 4'hB || segs !== 7'h79) begin
      failures++; $display("FAIL noload anode=%h segs=%h want B/79", anode, segs);
    end
    load = 1'b1;
    step(1); // c11
    load = 1'b0;
    checks++;
    if (anode !== 4'hB || segs !== 7'h00 || digit_idx !== 2'd2) begin
      failures++;
      $display("FAIL midslot_load anode=%h segs=%h idx=%0d want B/00/2", anode, segs, digit_idx);
    end
    step(1); // c12
    checks++;
    if (anode !== 4'hF || digit_idx !== 2'd3) begin
      failures++; $display("FAIL slot_len anode=%h idx=%0d want F/3", anode, digit_idx);
    end
    step(3); // c15
    value = 16'h2222; load = 1'b1;
    step(1); // c16 wrap edge
    load = 1'b0;
    step(1); // c17
    checks++;
    if (anode !== 4'hE || segs !== 7'h24) begin
      failures++; $display("FAIL wrap_load anode=%h segs=%h want E/24", anode, segs);
    end
  endtask

  task automatic test_back_to_back_rst;
    restart(16'h3333, 4'hF, 4'h0, 1'b0);
    step(12); // c13
    rst = 1'b1;
    step(1);
    checks++;
    if (anode !== 4'hF || segs !== 7'h7F || digit_idx !== 2'd0) begin
      failures++;
      $display("FAIL mid_rst anode=%h segs=%h idx=%0d want F/7F/0", anode, segs, digit_idx);
    end
    rst = 1'b0;
    step(1);
    checks++;
    if (anode !== 4'hF || digit_idx !== 2'd0) begin
      failures++; $display("FAIL rst_snap_clr anode=%h idx=%0d want F/0", anode, digit_idx);
    end
    step(3);
    checks++;
    if (digit_idx !== 2'd1) begin
      failures++; $display("FAIL rst_restart idx=%0d want 1", digit_idx);
    end
  endtask

  initial begin
    test_reset;
    test_scan;
    test_hex_decode;
    test_lz;
    test_en_dp;
    test_load_timing;
    test_back_to_back_rst;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
